uart_rcvr: RTL and testbench

Serial receiver for the UART path: the downstream partner of the UART transmitter. It oversamples the asynchronous serial line, detects and validates the start bit, shifts in a word LSB-first, checks the stop bit, and presents the received word to the host through a ready/read handshake. Overrun and framing faults are flagged as error pulses. Asynchronous active-low reset.

---
 rtl/uart_pkg.sv | 16 +
 rtl/uart_rcvr_if.sv | 41 ++++
 rtl/uart_sync2.sv | 27 ++
 rtl/uart_rcvr.sv | 167 ++++++++++++++++
 tb/tb_uart_rcvr.sv | 198 +++++++++++++++++++
 5 files changed

// File: rtl/uart_pkg.sv
// Shared UART definitions: receiver state encoding and frame-level constants.
// Used by both the transmitter and receiver sides of the UART path.
package uart_pkg;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        STARTING  = 2'd1,
        RECEIVING = 2'd2
    } rcv_state_e;

    localparam logic START_BIT = 1'b0;
    localparam logic STOP_BIT  = 1'b1;

    localparam int unsigned DEFAULT_WORD_SIZE = 8;

endpackage

// File: rtl/uart_rcvr_if.sv
// Host-side interface of the UART receiver: received word, ready/read handshake, error pulses.
// Error3 exists only when UART_RCVR_PARITY_EN is defined.
interface uart_rcvr_if
    import uart_pkg::*;
#(
    parameter int word_size = DEFAULT_WORD_SIZE
) ();

    logic                 Read_RCV_datareg;
    logic [word_size-1:0] RCV_datareg;
    logic                 RCV_ready;
    logic                 Error1;
    logic                 Error2;
`ifdef UART_RCVR_PARITY_EN
    logic                 Error3;
`endif

    // master is the receiver, slave is the host consuming words
    modport master (
        input  Read_RCV_datareg,
        output RCV_datareg,
        output RCV_ready,
        output Error1,
`ifdef UART_RCVR_PARITY_EN
        output Error3,
`endif
        output Error2
    );

    modport slave (
        output Read_RCV_datareg,
        input  RCV_datareg,
        input  RCV_ready,
        input  Error1,
`ifdef UART_RCVR_PARITY_EN
        input  Error3,
`endif
        input  Error2
    );

endinterface

// File: rtl/uart_sync2.sv
// Two-flop synchronizer for an asynchronous single-bit input, with a configurable reset level.
module uart_sync2 #(
    parameter logic RESET_VAL = 1'b1
) (
    input  logic clk,
    input  logic rst_n,
    input  logic async_i,
    output logic sync_o
);

    logic meta_q;
    logic sync_q;

    // NOTE: non-blocking assignments make both flops sample pre-edge values, forming a true 2-stage chain.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meta_q <= RESET_VAL;
            sync_q <= RESET_VAL;
        end else begin
            meta_q <= async_i;
            sync_q <= meta_q;
        end
    end

    assign sync_o = sync_q;

endmodule

// File: rtl/uart_rcvr.sv
// Oversampling UART receiver: start-bit validation, LSB-first shift, stop check, ready/read handshake.
// Define UART_RCVR_PARITY_EN to add an even-parity bit before the stop bit and the Error3 pulse.
module uart_rcvr
    import uart_pkg::*;
#(
    parameter int word_size  = DEFAULT_WORD_SIZE,
    parameter int OVERSAMPLE = 8
) (
    input  logic        Clock,
    input  logic        rst_b,
    input  logic        Serial_in,
    uart_rcvr_if.master host
);

    localparam int SAMPLE_W = $clog2(OVERSAMPLE);
    localparam int BIT_W    = $clog2(word_size + 3);

    localparam logic [SAMPLE_W-1:0] HALF_LAST   = SAMPLE_W'(OVERSAMPLE / 2 - 1);
    localparam logic [SAMPLE_W-1:0] SAMPLE_LAST = SAMPLE_W'(OVERSAMPLE - 1);
    localparam logic [BIT_W-1:0]    DATA_BITS   = BIT_W'(word_size);

    if (OVERSAMPLE < 4 || (OVERSAMPLE % 2) != 0) begin : g_bad_oversample
        $error("uart_rcvr: OVERSAMPLE must be even and at least 4");
    end

    logic rx_s;
    logic rx_prev_q;

    rcv_state_e           state_q, state_d;
    logic [SAMPLE_W-1:0]  sample_cnt_q, sample_cnt_d;
    logic [BIT_W-1:0]     bit_cnt_q, bit_cnt_d;
    logic [word_size-1:0] shift_q, shift_d;
    logic [word_size-1:0] data_q, data_d;
    logic                 ready_q, ready_d;
    logic                 err1_q, err1_d;
    logic                 err2_q, err2_d;
`ifdef UART_RCVR_PARITY_EN
    logic                 par_err_q, par_err_d;
    logic                 err3_q, err3_d;
`endif

    // The line idles at the stop level, so the synchronizer resets there to avoid a false start edge.
    uart_sync2 #(
        .RESET_VAL (STOP_BIT)
    ) u_sync (
        .clk     (Clock),
        .rst_n   (rst_b),
        .async_i (Serial_in),
        .sync_o  (rx_s)
    );

    always_comb begin
        // NOTE: every always_comb output takes a default first, so no path can infer a latch.
        state_d      = state_q;
        sample_cnt_d = sample_cnt_q;
        bit_cnt_d    = bit_cnt_q;
        shift_d      = shift_q;
        data_d       = data_q;
        ready_d      = ready_q & ~host.Read_RCV_datareg;
        err1_d       = 1'b0;
        err2_d       = 1'b0;
`ifdef UART_RCVR_PARITY_EN
        par_err_d    = par_err_q;
        err3_d       = 1'b0;
`endif

        unique case (state_q)
            IDLE: begin
                sample_cnt_d = '0;
                bit_cnt_d    = '0;
                if (rx_prev_q != START_BIT && rx_s == START_BIT) begin
                    state_d = STARTING;
                end
            end

            STARTING: begin
                if (rx_s != START_BIT) begin
                    sample_cnt_d = '0;
                    state_d      = IDLE;
                end else if (sample_cnt_q == HALF_LAST) begin
                    sample_cnt_d = '0;
                    state_d      = RECEIVING;
                end else begin
                    sample_cnt_d = sample_cnt_q + 1'b1;
                end
            end

            RECEIVING: begin
                if (sample_cnt_q != SAMPLE_LAST) begin
                    sample_cnt_d = sample_cnt_q + 1'b1;
                end else begin
                    sample_cnt_d = '0;
                    if (bit_cnt_q < DATA_BITS) begin
                        shift_d   = {rx_s, shift_q[word_size-1:1]};
                        bit_cnt_d = bit_cnt_q + 1'b1;
`ifdef UART_RCVR_PARITY_EN
                    end else if (bit_cnt_q == DATA_BITS) begin
                        par_err_d = rx_s ^ (^shift_q);
                        bit_cnt_d = bit_cnt_q + 1'b1;
`endif
                    end else begin
                        // Stop sample: exactly one outcome, framing first, then parity, then overrun.
                        state_d = IDLE;
                        if (rx_s != STOP_BIT) begin
                            err2_d = 1'b1;
`ifdef UART_RCVR_PARITY_EN
                        end else if (par_err_q) begin
                            err3_d = 1'b1;
`endif
                        end else if (ready_q && !host.Read_RCV_datareg) begin
                            err1_d = 1'b1;
                        end else begin
                            data_d  = shift_q;
                            ready_d = 1'b1;
                        end
                    end
                end
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // NOTE: the data and shift registers are reset too; they are single words, and the host sees 0 after reset.
    always_ff @(posedge Clock or negedge rst_b) begin
        if (!rst_b) begin
            state_q      <= IDLE;
            rx_prev_q    <= STOP_BIT;
            sample_cnt_q <= '0;
            bit_cnt_q    <= '0;
            shift_q      <= '0;
            data_q       <= '0;
            ready_q      <= 1'b0;
            err1_q       <= 1'b0;
            err2_q       <= 1'b0;
`ifdef UART_RCVR_PARITY_EN
            par_err_q    <= 1'b0;
            err3_q       <= 1'b0;
`endif
        end else begin
            state_q      <= state_d;
            rx_prev_q    <= rx_s;
            sample_cnt_q <= sample_cnt_d;
            bit_cnt_q    <= bit_cnt_d;
            shift_q      <= shift_d;
            data_q       <= data_d;
            ready_q      <= ready_d;
            err1_q       <= err1_d;
            err2_q       <= err2_d;
`ifdef UART_RCVR_PARITY_EN
            par_err_q    <= par_err_d;
            err3_q       <= err3_d;
`endif
        end
    end

    assign host.RCV_datareg = data_q;
    assign host.RCV_ready   = ready_q;
    assign host.Error1      = err1_q;
    assign host.Error2      = err2_q;
`ifdef UART_RCVR_PARITY_EN
    assign host.Error3      = err3_q;
`endif

endmodule

// File: tb/tb_uart_rcvr.sv
// Directed self-checking bench for uart_rcvr: exact stop-sample timing, glitch, framing, overrun, reset.
// Parity cases are included when UART_RCVR_PARITY_EN is defined.
module tb_uart_rcvr;

    localparam int WS = 8;
    localparam int OS = 8;
`ifdef UART_RCVR_PARITY_EN
    localparam int P = 1;
`else
    localparam int P = 0;
`endif

    logic Clock;
    logic rst_b;
    logic Serial_in;

    uart_rcvr_if #(.word_size(WS)) host_if ();

    uart_rcvr #(
        .word_size  (WS),
        .OVERSAMPLE (OS)
    ) dut (
        .Clock     (Clock),
        .rst_b     (rst_b),
        .Serial_in (Serial_in),
        .host      (host_if)
    );

    int checks   = 0;
    int failures = 0;
    int e1_cnt   = 0;
    int e2_cnt   = 0;
    int e3_cnt   = 0;

    logic          pre_ready, post_ready, post_e1, post_e2, post_e3, after_err;
    logic [WS-1:0] pre_data, post_data;
    logic          err3;

`ifdef UART_RCVR_PARITY_EN
    assign err3 = host_if.Error3;
`else
    assign err3 = 1'b0;
`endif

    initial Clock = 1'b0;
    always #5 Clock = ~Clock;

    always @(negedge Clock) begin
        if (host_if.Error1 === 1'b1) e1_cnt++;
        if (host_if.Error2 === 1'b1) e2_cnt++;
        if (err3 === 1'b1)           e3_cnt++;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic idle(input int n);
        Serial_in = 1'b1;
        repeat (n) @(negedge Clock);
    endtask

    task automatic host_read();
        host_if.Read_RCV_datareg = 1'b1;
        @(negedge Clock);
        host_if.Read_RCV_datareg = 1'b0;
    endtask

    // Called on a negedge. Outputs are captured one cycle before, on, and one cycle after the stop-sample edge.
    task automatic send_frame(input logic [WS-1:0] data, input logic stop_lvl, input logic par_lvl,
                              input logic rd_at_stop);
        Serial_in = 1'b0;
        repeat (OS) @(negedge Clock);
        for (int i = 0; i < WS + P; i++) begin
            Serial_in = (i < WS) ? data[i] : par_lvl;
            repeat (OS) @(negedge Clock);
        end
        Serial_in = stop_lvl;
        repeat (OS - 2) @(negedge Clock);
        pre_ready = host_if.RCV_ready;
        pre_data  = host_if.RCV_datareg;
        if (rd_at_stop) host_if.Read_RCV_datareg = 1'b1;
        @(negedge Clock);
        host_if.Read_RCV_datareg = 1'b0;
        post_ready = host_if.RCV_ready;
        post_data  = host_if.RCV_datareg;
        post_e1    = host_if.Error1;
        post_e2    = host_if.Error2;
        post_e3    = err3;
        @(negedge Clock);
        after_err = host_if.Error1 | host_if.Error2 | err3;
    endtask

    initial begin
        rst_b = 1'b0;
        Serial_in = 1'b1;
        host_if.Read_RCV_datareg = 1'b0;
        repeat (3) @(negedge Clock);
        check("rst_data",  host_if.RCV_datareg, 0);
        check("rst_ready", host_if.RCV_ready, 0);
        check("rst_err",   {host_if.Error1, host_if.Error2, err3}, 0);
        rst_b = 1'b1;
        idle(4);

        // Plain 0x41 frame; ready must rise exactly on the stop-sample edge.
        send_frame(8'h41, 1'b1, 1'b0, 1'b0);
        check("t1_pre_ready", pre_ready, 0);
        check("t1_data",      post_data, 8'h41);
        check("t1_ready",     post_ready, 1);
        check("t1_errs",      {post_e1, post_e2}, 0);
        idle(4);
        host_read();
        check("t1_read_clear", host_if.RCV_ready, 0);
        check("t1_data_kept",  host_if.RCV_datareg, 8'h41);

        // Three-cycle low glitch must not start a frame.
        Serial_in = 1'b0;
        repeat (3) @(negedge Clock);
        idle(20);
        check("t2_glitch_ready", host_if.RCV_ready, 0);
        check("t2_glitch_errs",  e1_cnt + e2_cnt, 0);
        send_frame(8'h42, 1'b1, 1'b0, 1'b0);
        check("t2_data",  post_data, 8'h42);
        check("t2_ready", post_ready, 1);
        host_read();
        check("t2_read_clear", host_if.RCV_ready, 0);

        // Framing error, then the line stays low: no re-arm.
        send_frame(8'h43, 1'b0, 1'b1, 1'b0);
        check("t3_e2",       post_e2, 1);
        check("t3_e1",       post_e1, 0);
        check("t3_data",     post_data, 8'h42);
        check("t3_ready",    post_ready, 0);
        check("t3_pulse_w",  after_err, 0);
        repeat (100) @(negedge Clock);
        check("t3_no_rearm", e2_cnt, 1);
        check("t3_ready_low", host_if.RCV_ready, 0);
        idle(20);

        // Overrun: two back-to-back frames without a read.
        send_frame(8'h41, 1'b1, 1'b0, 1'b0);
        check("t4_first_ready", post_ready, 1);
        send_frame(8'h42, 1'b1, 1'b0, 1'b0);
        check("t4_e1",       post_e1, 1);
        check("t4_e2",       post_e2, 0);
        check("t4_data",     post_data, 8'h41);
        check("t4_ready",    post_ready, 1);
        check("t4_pulse_w",  after_err, 0);
        check("t4_e1_count", e1_cnt, 1);

        // Read on the same edge as a load: the load wins.
        send_frame(8'h42, 1'b1, 1'b0, 1'b1);
        check("t5_data",     post_data, 8'h42);
        check("t5_ready",    post_ready, 1);
        check("t5_e1",       post_e1, 0);
        check("t5_e1_count", e1_cnt, 1);

        // Reset in the middle of data bit 1 while a word is pending.
        Serial_in = 1'b0;
        repeat (OS) @(negedge Clock);
        Serial_in = 1'b1;
        repeat (OS + 3) @(negedge Clock);
        rst_b = 1'b0;
        #1;
        check("t6_rst_data",  host_if.RCV_datareg, 0);
        check("t6_rst_ready", host_if.RCV_ready, 0);
        check("t6_rst_err",   {host_if.Error1, host_if.Error2, err3}, 0);
        @(negedge Clock);
        @(negedge Clock);
        rst_b = 1'b1;
        idle(20);
        send_frame(8'h55, 1'b1, 1'b0, 1'b0);
        check("t6_data",  post_data, 8'h55);
        check("t6_ready", post_ready, 1);
        check("t6_errs",  {post_e1, post_e2}, 0);

`ifdef UART_RCVR_PARITY_EN
        host_read();
        send_frame(8'h55, 1'b1, 1'b1, 1'b0);
        check("t7_e3",       post_e3, 1);
        check("t7_ready",    post_ready, 0);
        check("t7_data",     post_data, 8'h55);
        check("t7_e3_count", e3_cnt, 1);
`endif

        idle(4);
        check("final_e1_count", e1_cnt, 1);
        check("final_e2_count", e2_cnt, 1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
